// File: rtl/mdu_unit_if.sv
// MDU request/response bundle between the D-stage controller and the EX-stage MDU.
// Optional MDU_cancel exists only when MDU_CANCEL_EN is defined.
interface mdu_unit_if;
  logic [3:0]  MDU_op;
  logic        MDU_start;
  logic [31:0] MDU_A;
  logic [31:0] MDU_B;
`ifdef MDU_CANCEL_EN
  logic        MDU_cancel;
`endif
  logic        MDU_busy;
  logic [31:0] MDU_out;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  // Handshake: MDU_start is a one-cycle strobe qualified by MDU_op. It is
  // accepted only while MDU_busy is low. MDU_busy then stays high for exactly
  // the operation latency. There is no backpressure beyond busy: a start
  // presented while busy is dropped, and the controller must stall instead.
  modport slave (
    input  MDU_op, MDU_start, MDU_A, MDU_B,
`ifdef MDU_CANCEL_EN
    input  MDU_cancel,
`endif
    output MDU_busy, MDU_out, HI, LO, dbg_state
  );

  modport master (
    output MDU_op, MDU_start, MDU_A, MDU_B,
`ifdef MDU_CANCEL_EN
    output MDU_cancel,
`endif
    input  MDU_busy, MDU_out, HI, LO, dbg_state
  );
endinterface

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit holding HI/LO, with a fixed-latency busy window.
// Define MDU_CANCEL_EN to add the MDU_cancel abort input.
module mdu_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic       clk,
  input logic       reset_n,
  mdu_unit_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        cancel;

`ifdef MDU_CANCEL_EN
  assign cancel = bus.MDU_cancel;
`else
  assign cancel = 1'b0;
`endif

  logic [31:0] a, b;
  logic [3:0]  op;
  logic        is_arith, is_mult, is_signed_div;
  assign a = bus.MDU_A;
  assign b = bus.MDU_B;
  assign op = bus.MDU_op;
  assign is_arith      = (op[3:2] == 2'b00);
  assign is_mult       = (op == OP_MULT) || (op == OP_MULTU);
  assign is_signed_div = (op == OP_DIV);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  assign a_neg  = is_signed_div & a[31];
  assign b_neg  = is_signed_div & b[31];
  assign b_zero = (b == 32'd0);
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = b_neg ? (32'd0 - b) : b;
  assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.MDU_start && is_arith && !cancel) begin
          state_d = RUN;
          if (is_mult) begin
            cnt_d = 4'(MULT_LAT);
            res_d = (op == OP_MULT) ? prod_s : prod_u;
            wr_d  = 1'b1;
          end else begin
            cnt_d = 4'(DIV_LAT);
            res_d = {rem, quo};
            wr_d  = !b_zero;
          end
        end else if (op == OP_MTHI) begin
          hi_d = a;
        end else if (op == OP_MTLO) begin
          lo_d = a;
        end
      end
      RUN: begin
        if (cancel) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            if (wr_q) begin
              hi_d = res_q[63:32];
              lo_d = res_q[31:0];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.MDU_busy  = (cnt_q != 4'd0);
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.dbg_state = state_q;
  assign bus.MDU_out   = (op == OP_MFHI) ? hi_q :
                         (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed, table-driven bench for mdu_unit with hand-computed HI/LO results.
module tb_mdu_unit;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  mdu_unit_if bus();
  mdu_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.MDU_op    = 4'b1111;
    bus.MDU_start = 1'b0;
    bus.MDU_A     = 32'd0;
    bus.MDU_B     = 32'd0;
`ifdef MDU_CANCEL_EN
    bus.MDU_cancel = 1'b0;
`endif
  endtask

  task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    bus.MDU_op = 4'b0110; bus.MDU_A = hi;
    @(negedge clk);
    bus.MDU_op = 4'b0111; bus.MDU_A = lo;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.MDU_op = op; bus.MDU_start = 1'b1; bus.MDU_A = a; bus.MDU_B = b;
    @(negedge clk);
    drive_idle();
  endtask

  // Counts negedges with busy high, starting at the negedge right after the start edge.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.MDU_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{4'b0000, 32'hFFFFFFFD, 32'd7,        32'h0, 32'h0, 5,  32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7"};
    vecs[1] = '{4'b0001, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, 5,  32'h00000001, 32'hFFFFFFFE, "multu_max_x2"};
    vecs[2] = '{4'b0010, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_by2"};
    vecs[3] = '{4'b0011, 32'h0000000A, 32'd0,        32'h11, 32'h22, 10, 32'h00000011, 32'h00000022, "divu_by_zero"};
    vecs[4] = '{4'b0010, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 10, 32'h00000000, 32'h80000000, "div_min_by_m1"};
    vecs[5] = '{4'b0011, 32'd100,      32'd7,        32'h0, 32'h0, 10, 32'h00000002, 32'h0000000E, "divu_100_by7"};
    vecs[6] = '{4'b0000, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 5,  32'h00000001, 32'h00000000, "mult_2p16_sq"};
    vecs[7] = '{4'b0010, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 10, 32'h00000001, 32'hFFFFFFFD, "div_7_by_neg2"};

    // Reset state
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.MDU_busy}, 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    bus.MDU_op = 4'b0100;
    #1 chk("reset_mfhi", bus.MDU_out, 32'd0);
    bus.MDU_op = 4'b1111;
    #1 chk("none_out", bus.MDU_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      count_busy(n);
      chk({vecs[i].name, "_lat"}, 32'(n), 32'(vecs[i].lat));
      chk({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
      bus.MDU_op = 4'b0100;
      #1 chk({vecs[i].name, "_mfhi"}, bus.MDU_out, vecs[i].hi);
      bus.MDU_op = 4'b0101;
      #1 chk({vecs[i].name, "_mflo"}, bus.MDU_out, vecs[i].lo);
      bus.MDU_op = 4'b1111;
    end

    // mtlo in IDLE: single cycle, no busy
    @(negedge clk);
    bus.MDU_op = 4'b0111; bus.MDU_A = 32'h0000ABCD;
    @(negedge clk);
    drive_idle();
    chk("mtlo_lo", bus.LO, 32'h0000ABCD);
    chk("mtlo_busy", {31'd0, bus.MDU_busy}, 32'd0);

    // Start with a non-arithmetic op does nothing
    @(negedge clk);
    bus.MDU_op = 4'b0100; bus.MDU_start = 1'b1; bus.MDU_A = 32'd9; bus.MDU_B = 32'd9;
    @(negedge clk);
    drive_idle();
    chk("start_mfhi_busy", {31'd0, bus.MDU_busy}, 32'd0);
    chk("start_mfhi_lo", bus.LO, 32'h0000ABCD);

    // mthi and a second start while busy are both ignored; mfhi reads old HI
    set_hilo(32'h77, 32'h66);
    start_op(4'b0000, 32'd3, 32'd4);
    bus.MDU_op = 4'b0100;
    #1 chk("mfhi_busy_old", bus.MDU_out, 32'h77);
    bus.MDU_op = 4'b0110; bus.MDU_A = 32'h12345678;
    @(negedge clk);
    bus.MDU_op = 4'b0011; bus.MDU_start = 1'b1; bus.MDU_A = 32'd50; bus.MDU_B = 32'd5;
    @(negedge clk);
    drive_idle();
    count_busy(n);
    chk("busy_viol_lat", 32'(n + 2), 32'd5);
    chk("busy_viol_hi", bus.HI, 32'd0);
    chk("busy_viol_lo", bus.LO, 32'd12);

    // Reset mid-divide
    set_hilo(32'h99, 32'h88);
    start_op(4'b0010, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, bus.MDU_busy}, 32'd0);
    chk("rst_mid_hi", bus.HI, 32'd0);
    chk("rst_mid_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_after_hi", bus.HI, 32'd0);
    chk("rst_after_lo", bus.LO, 32'd0);
    chk("rst_after_busy", {31'd0, bus.MDU_busy}, 32'd0);

`ifdef MDU_CANCEL_EN
    // Cancel mid-multiply keeps the pre-operation HI/LO
    set_hilo(32'h33, 32'h44);
    start_op(4'b0000, 32'd5, 32'd5);
    @(negedge clk);
    bus.MDU_cancel = 1'b1;
    @(negedge clk);
    bus.MDU_cancel = 1'b0;
    chk("cancel_busy", {31'd0, bus.MDU_busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("cancel_hi", bus.HI, 32'h33);
    chk("cancel_lo", bus.LO, 32'h44);
    // Cancel and start on the same edge: start dropped
    @(negedge clk);
    bus.MDU_op = 4'b0001; bus.MDU_start = 1'b1; bus.MDU_A = 32'd2; bus.MDU_B = 32'd2;
    bus.MDU_cancel = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("cancel_start_busy", {31'd0, bus.MDU_busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("cancel_start_lo", bus.LO, 32'h44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
